// File: rtl/switch_output_buf_if.sv
// switch_output_buf_if: the output buffer's configuration, input, output and status signals.
// With SWITCH_OUT_XFER_CNT_EN defined it also carries the 16-bit pop counter.
interface switch_output_buf_if #(
    parameter int WIDTH  = 32,
    parameter int N_IN   = 5,
    parameter int DEPTH  = 2,
    parameter int CONF_W = 4
);
    logic                        conf_we;
    logic [CONF_W-1:0]           conf_in;
    logic [CONF_W-1:0]           conf_q;
    logic [N_IN*WIDTH-1:0]       d_in;
    logic [N_IN-1:0]             v_in;
    logic [N_IN-1:0]             rdy_in;
    logic [N_IN-1:0]             select;
    logic [WIDTH-1:0]            d_out;
    logic                        v_out;
    logic                        rdy_out;
    logic                        flush;
    logic [$clog2(DEPTH):0]      occ;
`ifdef SWITCH_OUT_XFER_CNT_EN
    logic [15:0]                 xfer_cnt;

    modport master (
        output conf_we, conf_in, d_in, v_in, rdy_out, flush,
        input  conf_q, rdy_in, select, d_out, v_out, occ, xfer_cnt
    );
    modport slave (
        input  conf_we, conf_in, d_in, v_in, rdy_out, flush,
        output conf_q, rdy_in, select, d_out, v_out, occ, xfer_cnt
    );
`else
    modport master (
        output conf_we, conf_in, d_in, v_in, rdy_out, flush,
        input  conf_q, rdy_in, select, d_out, v_out, occ
    );
    modport slave (
        input  conf_we, conf_in, d_in, v_in, rdy_out, flush,
        output conf_q, rdy_in, select, d_out, v_out, occ
    );
`endif
endinterface

// File: rtl/switch_output_buf.sv
// switch_output_buf: configurable N_IN:1 switch output stage feeding a DEPTH-entry FIFO.
// Optional SWITCH_OUT_XFER_CNT_EN adds a 16-bit pop counter cleared only by rst.
module switch_output_buf #(
    parameter int WIDTH  = 32,
    parameter int N_IN   = 5,
    parameter int DEPTH  = 2,
    parameter int CONF_W = 4
) (
    input logic               clk,
    input logic               rst,
    switch_output_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [CONF_W-1:0] conf_q;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       occ;
    logic [N_IN-1:0]   select;
    logic [WIDTH-1:0]  d_sel;
    logic              v_sel, v_out, rdy, push, pop;

    // Off and out-of-range codes never match any i+1, so select stays zero.
    always_comb begin
        select = '0;
        d_sel  = '0;
        v_sel  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            select[i] = conf_q == CONF_W'(i + 1);
            if (select[i]) begin
                d_sel = bus.d_in[i*WIDTH +: WIDTH];
                v_sel = bus.v_in[i];
            end
        end
    end

    assign v_out = occ != '0;
    assign pop   = v_out & bus.rdy_out;
    assign rdy   = (occ != FULL_OCC) | pop;
    assign push  = v_sel & rdy;

    assign bus.conf_q = conf_q;
    assign bus.select = select;
    assign bus.rdy_in = select & {N_IN{rdy}};
    assign bus.v_out  = v_out;
    assign bus.d_out  = v_out ? mem[rd_ptr] : '0;
    assign bus.occ    = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conf_q <= '0;
        else if (bus.conf_we)
            conf_q <= bus.conf_in;
    end

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            occ    <= occ + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush)
            mem[wr_ptr] <= d_sel;
    end

`ifdef SWITCH_OUT_XFER_CNT_EN
    logic [15:0] xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_cnt <= '0;
        else if (pop && !bus.flush)
            xfer_cnt <= xfer_cnt + 16'd1;
    end

    assign bus.xfer_cnt = xfer_cnt;
`endif
endmodule

// File: tb/tb_switch_output_buf.sv
// tb_switch_output_buf: directed checks of reset, routing, back-pressure, reconfiguration and flush.
// Counter wrap is exercised only when SWITCH_OUT_XFER_CNT_EN is defined.
module tb_switch_output_buf;
    localparam int WIDTH  = 32;
    localparam int N_IN   = 5;
    localparam int DEPTH  = 2;
    localparam int CONF_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N_IN-1:0][WIDTH-1:0] din;
    int n_cmp = 0;
    int n_err = 0;

    switch_output_buf_if #(.WIDTH(WIDTH), .N_IN(N_IN), .DEPTH(DEPTH), .CONF_W(CONF_W)) sif ();

    switch_output_buf #(.WIDTH(WIDTH), .N_IN(N_IN), .DEPTH(DEPTH), .CONF_W(CONF_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif.slave)
    );

    assign sif.d_in = din;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_conf(input logic [CONF_W-1:0] c);
        sif.conf_we = 1'b1;
        sif.conf_in = c;
        step();
        sif.conf_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        for (int i = 0; i < N_IN; i++) din[i] = 32'hDEAD_0000 + i;
        sif.v_in    = 5'b11111;
        sif.conf_we = 1'b0;
        sif.conf_in = '0;
        sif.rdy_out = 1'b0;
        sif.flush   = 1'b0;
        #3;
        chk("rst_conf_q", sif.conf_q, 0);
        chk("rst_select", sif.select, 0);
        chk("rst_rdy_in", sif.rdy_in, 0);
        chk("rst_v_out", sif.v_out, 0);
        chk("rst_d_out", sif.d_out, 0);
        chk("rst_occ", sif.occ, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_off_occ", sif.occ, 0);
        chk("idle_off_rdy_in", sif.rdy_in, 0);

        // Route E (input 2, conf code 3) with the downstream always ready
        sif.v_in = '0;
        load_conf(4'd3);
        chk("e_conf_q", sif.conf_q, 3);
        chk("e_select", sif.select, 5'b00100);
        sif.rdy_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din[2]   = 32'hA0 + i;
            sif.v_in = 5'b11111;
            #1;
            chk("e_rdy_in", sif.rdy_in, 5'b00100);
            step();
            chk("e_v_out", sif.v_out, 1);
            chk("e_d_out", sif.d_out, 32'hA0 + i);
            chk("e_occ", sif.occ, 1);
        end
        sif.v_in = '0;
        step();
        chk("e_drain_v_out", sif.v_out, 0);
        chk("e_drain_d_out", sif.d_out, 0);
        chk("e_drain_occ", sif.occ, 0);

        // Back-pressure: fill, stall the third flit, then release
        sif.rdy_out = 1'b0;
        sif.v_in    = 5'b00100;
        din[2]      = 32'h11;
        #1;
        chk("bp_rdy_first", sif.rdy_in, 5'b00100);
        step();
        chk("bp_latency_d_out", sif.d_out, 32'h11);
        din[2] = 32'h22;
        step();
        din[2] = 32'h33;
        #1;
        chk("bp_full_occ", sif.occ, 2);
        chk("bp_full_rdy_in", sif.rdy_in, 0);
        chk("bp_full_head", sif.d_out, 32'h11);
        step();
        chk("bp_stall_occ", sif.occ, 2);
        chk("bp_stall_head", sif.d_out, 32'h11);
        sif.rdy_out = 1'b1;
        #1;
        chk("bp_pass_rdy_in", sif.rdy_in, 5'b00100);
        step();
        chk("bp_pass_occ", sif.occ, 2);
        chk("bp_pass_d_out", sif.d_out, 32'h22);
        sif.v_in = '0;
        step();
        chk("bp_tail_d_out", sif.d_out, 32'h33);
        chk("bp_tail_occ", sif.occ, 1);
        step();
        chk("bp_empty_v_out", sif.v_out, 0);

        // Off and out-of-range codes, plus the top valid code
        sif.rdy_out = 1'b0;
        load_conf(4'd0);
        sif.v_in = 5'b11111;
        #1;
        chk("off0_select", sif.select, 0);
        chk("off0_rdy_in", sif.rdy_in, 0);
        step();
        chk("off0_occ", sif.occ, 0);
        load_conf(4'd7);
        #1;
        chk("off7_select", sif.select, 0);
        chk("off7_rdy_in", sif.rdy_in, 0);
        step();
        chk("off7_occ", sif.occ, 0);
        sif.v_in = '0;
        load_conf(4'd5);
        chk("s_select", sif.select, 5'b10000);

        // Reconfigure from N to S with N flits queued
        load_conf(4'd2);
        chk("n_select", sif.select, 5'b00010);
        sif.v_in = 5'b00010;
        din[1]   = 32'h51;
        step();
        din[1]      = 32'h52;
        sif.conf_we = 1'b1;
        sif.conf_in = 4'd5;
        step();
        sif.conf_we = 1'b0;
        chk("rc_conf_q", sif.conf_q, 5);
        chk("rc_old_conf_push_occ", sif.occ, 2);
        chk("rc_head_n1", sif.d_out, 32'h51);
        din[4]      = 32'h61;
        sif.v_in    = 5'b10010;
        sif.rdy_out = 1'b1;
        #1;
        chk("rc_rdy_in_s", sif.rdy_in, 5'b10000);
        step();
        chk("rc_head_n2", sif.d_out, 32'h52);
        din[4] = 32'h62;
        step();
        chk("rc_head_s1", sif.d_out, 32'h61);
        chk("rc_occ", sif.occ, 2);
        sif.flush = 1'b1;
        step();
        sif.flush = 1'b0;
        chk("flush_v_out", sif.v_out, 0);
        chk("flush_d_out", sif.d_out, 0);
        chk("flush_occ", sif.occ, 0);
        chk("flush_conf_q", sif.conf_q, 5);
        sif.v_in = '0;

        // Asynchronous reset between edges discards queued data
        sif.rdy_out = 1'b0;
        sif.v_in    = 5'b10000;
        step();
        chk("ar_pre_occ", sif.occ, 1);
        sif.v_in = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_occ", sif.occ, 0);
        chk("ar_v_out", sif.v_out, 0);
        chk("ar_conf_q", sif.conf_q, 0);
        step();
        rst = 1'b0;

`ifdef SWITCH_OUT_XFER_CNT_EN
        chk("cnt_rst", sif.xfer_cnt, 0);
        load_conf(4'd1);
        sif.rdy_out = 1'b1;
        sif.v_in    = 5'b00001;
        for (int i = 0; i < 32'hFFFF; i++) step();
        chk("cnt_fffe", sif.xfer_cnt, 16'hFFFE);
        sif.v_in = '0;
        step();
        chk("cnt_ffff", sif.xfer_cnt, 16'hFFFF);
        sif.v_in = 5'b00001;
        step();
        sif.v_in = '0;
        step();
        chk("cnt_wrap", sif.xfer_cnt, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
